accum_divider_16_bit: RTL and testbench

Sequential 16-bit by 10-bit unsigned restoring divider, one quotient bit per clock. It is the inverse companion of the accumulating adder datapath: the adder builds a value by repeated addition of the switch operand, and this block decomposes a register value into quotient and remainder by that same operand. It sits between the accumulator register output (dividend) and the switch bank (divisor), and its results feed the existing hex display drivers. It has its own start/busy/done handshake.

---
 rtl/accum_divider_16_bit.sv | 121 ++++++++++++
 tb/tb_accum_divider_16_bit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/accum_divider_16_bit.sv
// Sequential 16-bit by 10-bit unsigned restoring divider, one quotient bit per clock.
// A request is accepted on a rising Start level in IDLE. The block then parks in HOLD until
// Start drops, so a held button yields exactly one operation.
module accum_divider_16_bit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] dividend_i,
  input  logic [9:0]  divisor_i,
  output logic [15:0] quotient_o,
  output logic [9:0]  remainder_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        div_by_zero_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

  state_e      state_q;
  logic [15:0] q_q;
  logic [10:0] r_q;
  logic [9:0]  d_q;
  logic [4:0]  cnt_q;

  logic [15:0] quotient_q;
  logic [9:0]  remainder_q;
  logic        busy_q;
  logic        done_q;
  logic        div_by_zero_q;

  logic [10:0] shifted;
  logic [11:0] diff;
  logic        borrow;
  logic [10:0] r_d;
  logic [15:0] q_d;

  // R never exceeds D, so its top bit stays zero; it is kept only for the subtract width.
  logic unused_r_msb;
  assign unused_r_msb = r_q[10];

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  always_comb begin
    shifted = {r_q[9:0], q_q[15]};
    diff    = {1'b0, shifted} - {2'b00, d_q};
    borrow  = diff[11];
    if (borrow) begin
      r_d = shifted;
      q_d = {q_q[14:0], 1'b0};
    end else begin
      r_d = diff[10:0];
      q_d = {q_q[14:0], 1'b1};
    end
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      q_q           <= '0;
      r_q           <= '0;
      d_q           <= '0;
      cnt_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (divisor_i != 10'd0) begin
              q_q           <= dividend_i;
              r_q           <= '0;
              d_q           <= divisor_i;
              cnt_q         <= '0;
              busy_q        <= 1'b1;
              done_q        <= 1'b0;
              div_by_zero_q <= 1'b0;
              state_q       <= StCalc;
            end else begin
              // Divide by zero completes immediately with a saturated quotient.
              quotient_q    <= 16'hFFFF;
              remainder_q   <= '0;
              div_by_zero_q <= 1'b1;
              done_q        <= 1'b1;
              state_q       <= StHold;
            end
          end
        end
        StCalc: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            quotient_q  <= q_d;
            remainder_q <= r_d[9:0];
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (!start_i) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = div_by_zero_q;

endmodule

// File: tb/tb_accum_divider_16_bit.sv
// Self-checking bench for accum_divider_16_bit against plain / and % arithmetic.
module tb_accum_divider_16_bit;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] dividend_i;
  logic [9:0]  divisor_i;
  logic [15:0] quotient_o;
  logic [9:0]  remainder_o;
  logic        busy_o;
  logic        done_o;
  logic        div_by_zero_o;

  int n_checks;
  int n_fail;

  // Model state: the result the block should currently be showing.
  logic [15:0] exp_q_last;
  logic [9:0]  exp_r_last;

  accum_divider_16_bit u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .div_by_zero_o(div_by_zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait out a CALC window sampling on falling edges; returns busy cycle count and
  // whether the visible result stayed at the previous value throughout.
  task automatic wait_busy(output int cyc, output bit stable);
    cyc    = 0;
    stable = 1'b1;
    while (busy_o === 1'b1 && cyc < 40) begin
      if (quotient_o !== exp_q_last || remainder_o !== exp_r_last || done_o !== 1'b0)
        stable = 1'b0;
      cyc++;
      @(negedge clk_i);
    end
  endtask

  // Full request: present operands, pulse Start for one cycle, check results.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [9:0] b);
    int cyc;
    bit stable;
    logic [15:0] eq;
    logic [9:0]  er;
    @(negedge clk_i);
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    if (b == 10'd0) begin
      eq = 16'hFFFF;
      er = 10'd0;
      check({tag, ".dz_busy"}, {31'd0, busy_o}, 32'd0);
      check({tag, ".dz_flag"}, {31'd0, div_by_zero_o}, 32'd1);
    end else begin
      eq = a / {6'd0, b};
      er = 10'(a % {6'd0, b});
      check({tag, ".busy_on"}, {31'd0, busy_o}, 32'd1);
      wait_busy(cyc, stable);
      check({tag, ".busy_len"}, cyc, 32'd16);
      check({tag, ".stable"}, {31'd0, stable}, 32'd1);
      check({tag, ".dz_flag"}, {31'd0, div_by_zero_o}, 32'd0);
      check({tag, ".invariant"}, {16'd0, eq} * {22'd0, b} + {22'd0, er}, {16'd0, a});
    end
    check({tag, ".done"}, {31'd0, done_o}, 32'd1);
    check({tag, ".quot"}, {16'd0, quotient_o}, {16'd0, eq});
    check({tag, ".rem"}, {22'd0, remainder_o}, {22'd0, er});
    exp_q_last = eq;
    exp_r_last = er;
    @(negedge clk_i);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    bit stable;
    logic [15:0] ra;
    logic [9:0]  rb;
    n_checks   = 0;
    n_fail     = 0;
    exp_q_last = '0;
    exp_r_last = '0;
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (3) @(negedge clk_i);
    check("rst.quot", {16'd0, quotient_o}, 32'd0);
    check("rst.rem", {22'd0, remainder_o}, 32'd0);
    check("rst.flags", {29'd0, busy_o, done_o, div_by_zero_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed cases
    do_op("d1000_7", 16'd1000, 10'd7);
    do_op("d1234_3ff", 16'h1234, 10'h3FF);
    do_op("dffff_1", 16'hFFFF, 10'd1);
    do_op("d5_10", 16'd5, 10'd10);
    do_op("dzero", 16'hABCD, 10'd0);
    do_op("dafter_zero", 16'd77, 10'd5);

    // Start held for 50 cycles: exactly one operation
    dividend_i = 16'd100;
    divisor_i  = 10'd3;
    start_i    = 1'b1;
    busy_cnt   = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (busy_o === 1'b1) busy_cnt++;
    end
    check("hold.busy_total", busy_cnt, 32'd16);
    check("hold.quot", {16'd0, quotient_o}, 32'd33);
    check("hold.rem", {22'd0, remainder_o}, 32'd1);
    exp_q_last = 16'd33;
    exp_r_last = 10'd1;
    start_i = 1'b0;
    @(negedge clk_i);
    do_op("hold.second", 16'd0, 10'd3);

    // Operand churn and Start pulses during CALC are ignored
    @(negedge clk_i);
    dividend_i = 16'd60000;
    divisor_i  = 10'd250;
    start_i    = 1'b1;
    @(negedge clk_i);
    check("churn.busy_on", {31'd0, busy_o}, 32'd1);
    cyc = 0;
    while (busy_o === 1'b1 && cyc < 40) begin
      dividend_i = 16'($urandom);
      divisor_i  = 10'($urandom);
      start_i    = ~start_i;
      cyc++;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    check("churn.busy_len", cyc, 32'd16);
    check("churn.quot", {16'd0, quotient_o}, 32'd240);
    check("churn.rem", {22'd0, remainder_o}, 32'd0);
    exp_q_last = 16'd240;
    exp_r_last = 10'd0;
    @(negedge clk_i);

    // Reset mid-CALC aborts; Start already high on release is accepted on the first edge
    @(negedge clk_i);
    dividend_i = 16'd1000;
    divisor_i  = 10'd7;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (7) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("rstmid.quot", {16'd0, quotient_o}, 32'd0);
    check("rstmid.rem", {22'd0, remainder_o}, 32'd0);
    check("rstmid.flags", {29'd0, busy_o, done_o, div_by_zero_o}, 32'd0);
    exp_q_last = '0;
    exp_r_last = '0;
    start_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("rstmid.accept", {31'd0, busy_o}, 32'd1);
    wait_busy(cyc, stable);
    check("rstmid.busy_len", cyc, 32'd16);
    check("rstmid.stable", {31'd0, stable}, 32'd1);
    check("rstmid.quot", {16'd0, quotient_o}, 32'd142);
    check("rstmid.rem", {22'd0, remainder_o}, 32'd6);
    exp_q_last = 16'd142;
    exp_r_last = 10'd6;
    @(negedge clk_i);

    // Randomized operands, occasionally a zero divisor
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
      do_op("rand", ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
